// File: rtl/golden_nonce_tx_pkg.sv
// Shared definitions for the golden-nonce return path and the uart_comm receiver.
package golden_nonce_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int FRAME_BYTES = 4;
  localparam int BYTE_IDX_W  = $clog2(FRAME_BYTES) + 1;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/golden_nonce_tx_uart_tx_byte.sv
// 8N1 byte serializer with bit timer. A byte offered during the last stop-bit
// cycle is chained straight into the next start bit, so multi-byte frames have no gap.
module uart_tx_byte
  import golden_nonce_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       take_o,
  output logic       tx_o
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;
  logic          stop_end;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign stop_end = (state_q == STOP) && bit_end;
  assign ready_o  = (state_q == IDLE);
  assign take_o   = valid_i && (ready_o || stop_end);
  assign tx_o     = tx_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // NOTE: every next-state signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (valid_i) begin
          state_d = START;
          shift_d = data_i;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (valid_i) begin
            state_d = START;
            shift_d = data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/golden_nonce_tx.sv
// Golden-nonce return path: FIFO of nonces, each sent as four little-endian 8N1 bytes.
module golden_nonce_tx
  import golden_nonce_tx_pkg::*;
#(
  parameter int BAUD_RATE    = 9600,
  parameter int SYS_CLK_FREQ = 12000000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        comm_clk,
  input  logic                        reset,
  input  logic [31:0]                 golden_nonce,
  input  logic                        new_golden_nonce,
  output logic                        tx_serial,
  output logic                        tx_busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int CLKS_PER_BIT = clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
  localparam int AW           = $clog2(FIFO_DEPTH);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("golden_nonce_tx: CLKS_PER_BIT must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("golden_nonce_tx: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  logic [31:0]           mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic [23:0]           rest_q, rest_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;

  logic        empty, full, push_ok, pop;
  logic [31:0] head;
  logic        start_frame, more_bytes;
  logic        byte_valid, ser_ready, ser_take;
  logic [7:0]  byte_data;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // A new word is only taken while the serializer idles, giving one idle cycle between frames.
  assign start_frame = ser_ready && !empty;
  assign more_bytes  = (byte_idx_q != '0) && (byte_idx_q != BYTE_IDX_W'(FRAME_BYTES));
  assign byte_valid  = start_frame || more_bytes;
  assign byte_data   = start_frame ? head[7:0] : rest_q[7:0];
  assign pop         = ser_take && start_frame;
  assign push_ok     = new_golden_nonce && (!full || pop);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_i  (comm_clk),
    .rst_i  (reset),
    .valid_i(byte_valid),
    .data_i (byte_data),
    .ready_o(ser_ready),
    .take_o (ser_take),
    .tx_o   (tx_serial)
  );

  // NOTE: the storage array carries no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge comm_clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= golden_nonce;
  end

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q || (new_golden_nonce && !push_ok);
    rest_d     = rest_q;
    byte_idx_d = byte_idx_q;
    if (ser_take) begin
      if (start_frame) begin
        rest_d     = head[31:8];
        byte_idx_d = BYTE_IDX_W'(1);
      end else begin
        rest_d     = {8'h00, rest_q[23:8]};
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge comm_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      rest_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      rest_q     <= rest_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  assign tx_busy    = !ser_ready || !empty;
  assign overflow   = overflow_q;
  assign fifo_level = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_golden_nonce_tx.sv
// Self-checking bench for golden_nonce_tx: per-cycle timeline model plus directed frame decodes.
module tb_golden_nonce_tx;

  localparam int CPB       = 16;
  localparam int DEPTH     = 4;
  localparam int FRAME_CYC = 40 * CPB;

  logic        comm_clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] golden_nonce = '0;
  logic        new_golden_nonce = 1'b0;
  logic        tx_serial, tx_busy, overflow;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  golden_nonce_tx #(
    .BAUD_RATE   (1),
    .SYS_CLK_FREQ(16),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .comm_clk        (comm_clk),
    .reset           (reset),
    .golden_nonce    (golden_nonce),
    .new_golden_nonce(new_golden_nonce),
    .tx_serial       (tx_serial),
    .tx_busy         (tx_busy),
    .overflow        (overflow),
    .fifo_level      (fifo_level)
  );

  always #5 comm_clk = ~comm_clk;
  always @(posedge comm_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: queue of held nonces plus the elapsed time inside the frame on the line.
  logic [31:0] mq[$];
  bit          m_in_frame = 0;
  int          m_e = 0;
  logic [31:0] m_word = '0;
  bit          m_ovf = 0;
  logic        s_push, s_rst;
  logic [31:0] s_val;
  logic [5:0]  exp_v;

  task automatic model_step(input logic push, input logic [31:0] val);
    if (m_in_frame) begin
      m_e++;
      if (m_e == FRAME_CYC) m_in_frame = 0;
    end else if (mq.size() > 0) begin
      m_word     = mq.pop_front();
      m_in_frame = 1;
      m_e        = 0;
    end
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(val);
      else m_ovf = 1;
    end
  endtask

  function automatic logic model_line();
    int b, by, pos;
    if (!m_in_frame) return 1'b1;
    b   = m_e / CPB;
    by  = b / 10;
    pos = b % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_word[by*8 + pos - 1];
  endfunction

  initial begin
    forever begin
      @(posedge comm_clk);
      s_push = new_golden_nonce;
      s_val  = golden_nonce;
      s_rst  = reset;
      @(negedge comm_clk);
      if (s_rst || reset) begin
        mq.delete();
        m_in_frame = 0;
        m_e        = 0;
        m_ovf      = 0;
      end else begin
        model_step(s_push, s_val);
      end
      exp_v = {model_line(), (m_in_frame || mq.size() != 0), m_ovf, 3'(mq.size())};
      check("cycle_model", {tx_serial, tx_busy, overflow, fifo_level}, exp_v);
    end
  end

  task automatic drive_push(input logic [31:0] v);
    golden_nonce     = v;
    new_golden_nonce = 1'b1;
    @(negedge comm_clk);
    new_golden_nonce = 1'b0;
  endtask

  task automatic wait_offset(input int start, input int off);
    while (cyc - start < off) @(negedge comm_clk);
  endtask

  // Samples each bit mid-period; start is the cycle count at the first negedge of the start bit.
  task automatic decode_frame(input int known, output logic [31:0] w, output int start, output bit ok);
    int n;
    int pos;
    n  = 0;
    w  = '0;
    ok = 1;
    if (known >= 0) begin
      start = known;
    end else begin
      while (tx_serial !== 1'b0 && n < 2000) begin
        @(negedge comm_clk);
        n++;
      end
      start = cyc;
      if (tx_serial !== 1'b0) begin
        check("frame_start_timeout", tx_serial, 1'b0);
        ok = 0;
        return;
      end
    end
    for (int b = 0; b < 40; b++) begin
      wait_offset(start, b * CPB + CPB / 2);
      pos = b % 10;
      if (pos == 0) ok = ok && (tx_serial === 1'b0);
      else if (pos == 9) ok = ok && (tx_serial === 1'b1);
      else w[(b / 10) * 8 + pos - 1] = tx_serial;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] v;
    int          s, s1, s2, p;
    bit          ok;
    logic [31:0] expq[$];

    repeat (3) @(negedge comm_clk);
    @(posedge comm_clk);
    #3 reset = 1'b0;

    // 1: quiet line after reset
    repeat (1000) @(negedge comm_clk);
    check("t1_tx_idle", tx_serial, 1'b1);
    check("t1_busy", tx_busy, 1'b0);
    check("t1_level", fifo_level, 3'd0);
    check("t1_ovf", overflow, 1'b0);

    // 2: single nonce, bytes EF BE AD DE
    drive_push(32'hDEADBEEF);
    p = cyc;
    decode_frame(-1, w, s, ok);
    check("t2_start_latency", s - p, 1);
    check("t2_word", w, 32'hDEADBEEF);
    check("t2_framing", ok, 1'b1);
    wait_offset(s, FRAME_CYC - 1);
    check("t2_busy_last_stop", tx_busy, 1'b1);
    wait_offset(s, FRAME_CYC);
    check("t2_busy_drop", tx_busy, 1'b0);
    check("t2_line_high", tx_serial, 1'b1);

    // 3: two nonces on consecutive cycles
    repeat (5) @(negedge comm_clk);
    drive_push(32'h00000001);
    p = cyc;
    check("t3_high_before_start", tx_serial, 1'b1);
    drive_push(32'h80000000);
    check("t3_start_bit", tx_serial, 1'b0);
    decode_frame(p + 1, w, s1, ok);
    check("t3_word0", w, 32'h00000001);
    check("t3_framing0", ok, 1'b1);
    decode_frame(-1, w, s2, ok);
    check("t3_word1", w, 32'h80000000);
    check("t3_framing1", ok, 1'b1);
    check("t3_frame_spacing", s2 - s1, FRAME_CYC + 1);

    // 4: five pushes into a busy line with a 4-deep buffer
    wait_offset(s2, FRAME_CYC + 20);
    drive_push(32'hA5A50F0F);
    p = cyc;
    expq.delete();
    expq.push_back(32'hA5A50F0F);
    @(negedge comm_clk);
    for (int i = 1; i <= 4; i++) begin
      v = 32'h11111111 * i;
      drive_push(v);
      expq.push_back(v);
    end
    check("t4_level_full", fifo_level, 3'd4);
    check("t4_ovf_clear", overflow, 1'b0);
    drive_push(32'h55555555);
    check("t4_ovf_set", overflow, 1'b1);
    check("t4_level_held", fifo_level, 3'd4);
    for (int i = 0; i < 5; i++) begin
      decode_frame((i == 0) ? p + 1 : -1, w, s, ok);
      check("t4_word", w, expq[i]);
      check("t4_framing", ok, 1'b1);
    end
    wait_offset(s, FRAME_CYC + 20);
    check("t4_level_drained", fifo_level, 3'd0);
    check("t4_ovf_sticky", overflow, 1'b1);

    // 5: reset during data bit 3 of byte 2
    drive_push(32'hCAF7F00D);
    p = cyc;
    drive_push(32'h12345678);
    wait_offset(p + 1, 2 * 10 * CPB + 4 * CPB + 5);
    check("t5_level_pre", fifo_level, 3'd1);
    check("t5_bit_pre", tx_serial, 1'b0);
    @(posedge comm_clk);
    #3 reset = 1'b1;
    #1;
    check("t5_tx_reset", tx_serial, 1'b1);
    check("t5_level_reset", fifo_level, 3'd0);
    check("t5_busy_reset", tx_busy, 1'b0);
    check("t5_ovf_reset", overflow, 1'b0);
    repeat (2) @(posedge comm_clk);
    #3 reset = 1'b0;
    @(negedge comm_clk);
    check("t5_no_resume", tx_busy, 1'b0);
    drive_push(32'h0BADC0DE);
    p = cyc;
    decode_frame(-1, w, s, ok);
    check("t5_start_latency", s - p, 1);
    check("t5_word", w, 32'h0BADC0DE);
    check("t5_framing", ok, 1'b1);
    wait_offset(s, FRAME_CYC + 20);

    // 6: push at the idle-pop edge while full
    drive_push(32'h01020304);
    p = cyc;
    expq.delete();
    for (int i = 1; i <= 4; i++) begin
      v = 32'hF0000000 + i;
      drive_push(v);
      expq.push_back(v);
    end
    expq.push_back(32'h5A5A5A5A);
    check("t6_level_full", fifo_level, 3'd4);
    decode_frame(p + 1, w, s, ok);
    check("t6_word_first", w, 32'h01020304);
    wait_offset(s, FRAME_CYC);
    check("t6_idle_high", tx_serial, 1'b1);
    check("t6_idle_busy", tx_busy, 1'b1);
    drive_push(32'h5A5A5A5A);
    check("t6_level_same", fifo_level, 3'd4);
    check("t6_ovf_clear", overflow, 1'b0);
    check("t6_next_start", tx_serial, 1'b0);
    s = cyc;
    for (int i = 0; i < 5; i++) begin
      decode_frame((i == 0) ? s : -1, w, s, ok);
      check("t6_word", w, expq[i]);
      check("t6_framing", ok, 1'b1);
    end
    wait_offset(s, FRAME_CYC + 20);
    check("t6_level_end", fifo_level, 3'd0);
    check("t6_busy_end", tx_busy, 1'b0);
    check("t6_ovf_end", overflow, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
